i2s_tx: RTL

Serial audio output stage directly downstream of the 15 kHz output filter. Latches each filtered signed 16-bit sample, duplicates it to both channels, and serializes it as a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external DAC. The block generates its own bit and word clocks from the system clock and flags sample-rate mismatches between the filter and the serial frame.

---
 rtl/i2s_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serializer for the filtered audio stream.
// One signed 16-bit sample is latched per frame and sent on both the left
// and right channels. BCLK and LRCLK are derived from clk by a divider, and
// sticky flags report sample-rate mismatches between the filter and the frame.
module i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               iRstN,
    input  logic               iValid,
    input  logic signed [15:0] iIn,
    input  logic               iClr,
    output logic               oBclk,
    output logic               oLrclk,
    output logic               oSdata,
    output logic               oFrameStart,
    output logic               oUnderrun,
    output logic               oOverrun
);

    logic [7:0]  div;
    logic [4:0]  slot;
    logic [15:0] hold;
    logic        fresh;
    logic [31:0] frame;

    logic        bclkTick;
    logic        shiftEvent;
    logic        frameLoad;
    logic [4:0]  slotNext;
    logic [4:0]  bitIdx;
    logic        setUnderrun;
    logic        setOverrun;

    // Decode the divider and slot state into the events of this cycle.
    // bitIdx = 32 - slotNext (mod 32): slot 1 sends frame[31], slot 31 sends
    // frame[1], and slot 0 sends frame[0] of the frame being replaced.
    always_comb begin
        bclkTick    = (div == 8'(CLK_DIV - 1));
        shiftEvent  = bclkTick && oBclk;
        slotNext    = slot + 5'd1;
        frameLoad   = shiftEvent && (slot == 5'd31);
        bitIdx      = 5'd0 - slotNext;
        setUnderrun = frameLoad && !fresh;
        setOverrun  = iValid && fresh && !frameLoad;
    end

    // Divider that sets the BCLK half-period and toggles the bit clock.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            div   <= 8'd0;
            oBclk <= 1'b0;
        end else if (bclkTick) begin
            div   <= 8'd0;
            oBclk <= ~oBclk;
        end else begin
            div <= div + 8'd1;
        end
    end

    // Slot counter advancing on every BCLK falling edge, 32 slots per frame.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            slot <= 5'd31;
        end else if (shiftEvent) begin
            slot <= slotNext;
        end
    end

    // Holding register and fresh flag; a coincident load leaves the new sample
    // pending for the next frame.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            hold  <= 16'd0;
            fresh <= 1'b0;
        end else if (iValid) begin
            hold  <= iIn;
            fresh <= 1'b1;
        end else if (frameLoad) begin
            fresh <= 1'b0;
        end
    end

    // Frame register plus registered word select and serial data, which move
    // together on BCLK falling edges.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            frame       <= 32'd0;
            oLrclk      <= 1'b1;
            oSdata      <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oFrameStart <= frameLoad;
            if (frameLoad) begin
                frame <= {hold, hold};
            end
            if (shiftEvent) begin
                oLrclk <= slotNext[4];
                oSdata <= frame[bitIdx];
            end
        end
    end

    // Sticky error flags; a new set event takes priority over a clear.
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            oUnderrun <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            if (setUnderrun) begin
                oUnderrun <= 1'b1;
            end else if (iClr) begin
                oUnderrun <= 1'b0;
            end
            if (setOverrun) begin
                oOverrun <= 1'b1;
            end else if (iClr) begin
                oOverrun <= 1'b0;
            end
        end
    end

endmodule
